// File: rtl/turbo_rsc_viterbi_decoder.sv
// Hard-decision Viterbi decoder for the 8-state NB-IoT uplink RSC code.
// Define TURBO_DEC_TAIL_EN to consume the 3 termination steps and trace from state 0.
module turbo_rsc_viterbi_decoder #(
  parameter int K  = 40,
  parameter int MW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          sys_bit,
  input  logic          par_bit,
  output logic          in_ready,
  output logic [0:K-1]  dout,
  output logic          dout_valid,
  output logic [MW-1:0] err_metric
);

`ifdef TURBO_DEC_TAIL_EN
  localparam int N = K + 3;
`else
  localparam int N = K;
`endif
  localparam int CW = $clog2(N);
  localparam logic [MW-1:0] MAXM = '1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {RECV, TRACE, OUT} st_t;

  st_t           state_q, state_d;
  logic [MW-1:0] pm    [8];
  logic [MW-1:0] pm_nx [8];
  logic [7:0]    dec;
  logic [7:0]    surv  [N];
  logic [CW-1:0] cnt;
  logic [2:0]    tst;
  logic [2:0]    start;
  logic [2:0]    cur;
  logic [0:K-1]  dbuf;
  logic          acc;
  logic          td;
  logic          tbit;
  logic          wr_bit;

  function automatic logic [MW-1:0] sat_add(
    input logic [MW-1:0] a,
    input logic [1:0]    b
  );
    logic [MW:0] s;
    s = {1'b0, a} + {{(MW-1){1'b0}}, b};
    return s[MW] ? MAXM : s[MW-1:0];
  endfunction

  // ACS: next state {a,x,y} has predecessors {x,y,d}; u=a^y^d, z=a^x^d
  always_comb begin
    logic [2:0]    ns3;
    logic          u0, z0;
    logic [1:0]    b0, b1;
    logic [MW-1:0] c0, c1;
    dec = '0;
    pm_nx = pm;
    for (int ns = 0; ns < 8; ns++) begin
      ns3 = 3'(ns);
      u0 = ns3[2] ^ ns3[0];
      z0 = ns3[2] ^ ns3[1];
      b0 = {1'b0, sys_bit ^ u0} + {1'b0, par_bit ^ z0};
      b1 = {1'b0, sys_bit ^ ~u0} + {1'b0, par_bit ^ ~z0};
      c0 = sat_add(pm[{ns3[1:0], 1'b0}], b0);
      c1 = sat_add(pm[{ns3[1:0], 1'b1}], b1);
      dec[ns] = c1 < c0;
      pm_nx[ns] = (c1 < c0) ? c1 : c0;
    end
  end

  always_comb begin
    start = 3'd0;
`ifdef TURBO_DEC_TAIL_EN
    start = 3'd0;
`else
    for (int s = 1; s < 8; s++)
      if (pm[s] < pm[start]) start = 3'(s);
`endif
  end

  assign cur    = (cnt == LAST) ? start : tst;
  assign td     = surv[cnt][cur];
  assign tbit   = cur[2] ^ cur[0] ^ td;
  assign wr_bit = {1'b0, cnt} < (CW + 1)'(K);
  assign acc    = in_ready & in_valid;

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      RECV: begin
        in_ready = 1'b1;
        if (in_valid && cnt == LAST) state_d = TRACE;
      end
      TRACE: if (cnt == '0) state_d = OUT;
      OUT: state_d = RECV;
      default: state_d = RECV;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RECV;
      cnt        <= '0;
      tst        <= '0;
      dbuf       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err_metric <= '0;
      for (int s = 0; s < 8; s++)
        pm[s] <= (s == 0) ? '0 : MAXM;
    end else begin
      state_q    <= state_d;
      dout_valid <= 1'b0;
      unique case (state_q)
        RECV: begin
          if (in_valid) begin
            pm <= pm_nx;
            if (cnt != LAST) cnt <= cnt + CW'(1);
          end
        end
        TRACE: begin
          if (wr_bit) dbuf[cnt] <= tbit;
          tst <= {cur[1:0], td};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        OUT: begin
          dout       <= dbuf;
          dout_valid <= 1'b1;
          err_metric <= pm[start];
          cnt        <= '0;
          for (int s = 0; s < 8; s++)
            pm[s] <= (s == 0) ? '0 : MAXM;
        end
        default: ;
      endcase
    end
  end

  // Survivor rows need no reset; every block rewrites all of them.
  always_ff @(posedge clk) begin
    if (acc) surv[cnt] <= dec;
  end

endmodule

// File: tb/tb_turbo_rsc_viterbi_decoder.sv
// Bench for turbo_rsc_viterbi_decoder: RSC encoder model feeds blocks,
// expected words go to a scoreboard queue checked on dout_valid.
`timescale 1ns/1ps
module tb_turbo_rsc_viterbi_decoder;
  localparam int K  = 40;
  localparam int MW = 8;
`ifdef TURBO_DEC_TAIL_EN
  localparam int N = K + 3;
`else
  localparam int N = K;
`endif
  localparam logic [K-1:0] SRC_A = 40'hA5A5A5A5A5;
  localparam logic [K-1:0] SRC_B = 40'h123456789A;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          sys_bit;
  logic          par_bit;
  logic          in_ready;
  logic [0:K-1]  dout;
  logic          dout_valid;
  logic [MW-1:0] err_metric;

  turbo_rsc_viterbi_decoder #(.K(K), .MW(MW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .sys_bit    (sys_bit),
    .par_bit    (par_bit),
    .in_ready   (in_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .err_metric (err_metric)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int stall_cnt = 0;
  logic prev_dv = 1'b0;
  logic [0:K-1]  exp_d_q [$];
  logic [MW-1:0] exp_m_q [$];
  logic sys_s [K+3];
  logic par_s [K+3];

  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard: pop and compare whenever the DUT publishes a block
  always @(negedge clk) begin
    logic [0:K-1]  ed;
    logic [MW-1:0] em;
    if (!rst && dout_valid) begin
      checks++;
      if (prev_dv) begin
        errors++;
        $display("FAIL dv_pulse: dout_valid high 2 cycles, expected 1");
      end
      if (exp_d_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dout_valid: got 1 expected 0 at cycle %0d", cyc);
      end else begin
        ed = exp_d_q.pop_front();
        em = exp_m_q.pop_front();
        checks++;
        if (dout !== ed) begin
          errors++;
          $display("FAIL dout: got %h expected %h", dout, ed);
        end
        checks++;
        if (err_metric !== em) begin
          errors++;
          $display("FAIL err_metric: got %0d expected %0d", err_metric, em);
        end
        checks++;
        if (cyc - last_acc != N + 1) begin
          errors++;
          $display("FAIL latency: got %0d expected %0d", cyc - last_acc, N + 1);
        end
      end
    end
    prev_dv = dout_valid & !rst;
  end

  task automatic encode(input logic [K-1:0] src, input int fp, input int fs);
    logic s1, s2, s3, u, a;
    s1 = 1'b0; s2 = 1'b0; s3 = 1'b0;
    for (int i = 0; i < K + 3; i++) begin
      u = (i < K) ? src[K-1-i] : (s2 ^ s3);
      a = u ^ s2 ^ s3;
      sys_s[i] = u ^ (i == fs);
      par_s[i] = a ^ s1 ^ s3 ^ (i == fp);
      s3 = s2; s2 = s1; s1 = a;
    end
  endtask

  task automatic send(input int npairs, input bit toggle);
    int i;
    int waited;
    bit ph;
    i = 0; waited = 0; ph = 1'b0; stall_cnt = 0;
    while (i < npairs) begin
      @(negedge clk);
      ph = ~ph;
      if (toggle && !ph) begin
        in_valid = 1'b0;
        sys_bit = 1'($urandom);
        par_bit = 1'($urandom);
      end else if (in_ready) begin
        in_valid = 1'b1;
        sys_bit = sys_s[i];
        par_bit = par_s[i];
        if (i == N - 1) last_acc = cyc + 1;
        i++;
      end else begin
        in_valid = 1'b1;
        sys_bit = 1'($urandom);
        par_bit = 1'($urandom);
        stall_cnt++;
        waited++;
        if (waited > 4 * N + 10) begin
          checks++;
          errors++;
          $display("FAIL in_ready_timeout: got 0 expected 1 after %0d cycles", waited);
          i = npairs;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sys_bit = 1'b0; par_bit = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (dout !== '0) begin
      errors++; $display("FAIL rst_dout: got %h expected 0", dout);
    end
    checks++;
    if (dout_valid !== 1'b0) begin
      errors++; $display("FAIL rst_dout_valid: got %b expected 0", dout_valid);
    end
    checks++;
    if (err_metric !== '0) begin
      errors++; $display("FAIL rst_err_metric: got %0d expected 0", err_metric);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_ready: got %b expected 1", in_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_all_zero();
    encode('0, -1, -1);
    exp_d_q.push_back('0);
    exp_m_q.push_back('0);
    send(N, 1'b0);
  endtask

  task automatic test_clean();
    encode(SRC_A, -1, -1);
    exp_d_q.push_back(SRC_A);
    exp_m_q.push_back('0);
    send(N, 1'b0);
  endtask

  task automatic test_par_flip();
    encode(SRC_A, 10, -1);
    exp_d_q.push_back(SRC_A);
    exp_m_q.push_back(MW'(1));
    send(N, 1'b0);
  endtask

  task automatic test_sys_flip_stall();
    encode(SRC_A, -1, 20);
    exp_d_q.push_back(SRC_A);
    exp_m_q.push_back(MW'(1));
    send(N, 1'b1);
  endtask

  task automatic test_back_to_back();
    encode(SRC_B, -1, -1);
    exp_d_q.push_back(SRC_B);
    exp_m_q.push_back('0);
    send(N, 1'b0);
    encode(SRC_A, -1, -1);
    exp_d_q.push_back(SRC_A);
    exp_m_q.push_back('0);
    send(N, 1'b0);
    checks++;
    if (stall_cnt != N + 1) begin
      errors++;
      $display("FAIL b2b_stall: got %0d expected %0d", stall_cnt, N + 1);
    end
    encode(SRC_B, 5, -1);
    exp_d_q.push_back(SRC_B);
    exp_m_q.push_back(MW'(1));
    send(N, 1'b0);
  endtask

  task automatic test_reset_mid_block();
    encode(SRC_A, -1, -1);
    send(15, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (dout !== '0) begin
      errors++; $display("FAIL midrst_dout: got %h expected 0", dout);
    end
    checks++;
    if (err_metric !== '0) begin
      errors++; $display("FAIL midrst_err_metric: got %0d expected 0", err_metric);
    end
    rst = 1'b0;
    repeat (N + 5) @(negedge clk);
    checks++;
    if (dout !== '0 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_hold: got dout=%h dv=%b expected 0/0", dout, dout_valid);
    end
    exp_d_q.push_back(SRC_A);
    exp_m_q.push_back('0);
    send(N, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_all_zero();
    test_clean();
    test_par_flip();
    test_sys_flip_stall();
    test_back_to_back();
    test_reset_mid_block();
    for (int w = 0; w < 4 * N && exp_d_q.size() != 0; w++)
      @(negedge clk);
    repeat (2) @(negedge clk);
    checks++;
    if (exp_d_q.size() != 0) begin
      errors++;
      $display("FAIL pending_blocks: got %0d expected 0", exp_d_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
